// File: rtl/can_rx_pkg.sv
// Shared types and helpers for the CAN receive path.
// Holds the data-field capture FSM states, bit-stuffing and CRC-15 constants,
// and small combinational helper functions used by data_field_capture.
package can_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RECV  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } dfc_state_t;

    localparam logic [14:0] CAN_CRC15_POLY = 15'h4599;
    localparam logic [2:0]  STUFF_LIMIT    = 3'd5;
    localparam int          MAX_DLC_BYTES  = 8;

    // Majority of three samples.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // One CAN CRC-15 update step for a single data bit.
    function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic data_bit);
        logic fb;
        fb = data_bit ^ crc[14];
        return {crc[13:0], 1'b0} ^ (fb ? CAN_CRC15_POLY : 15'h0000);
    endfunction

    // Seed run length sanitised to 1..STUFF_LIMIT (0 counts as 1).
    function automatic logic [2:0] seed_run(input logic [2:0] cnt);
        logic [2:0] r;
        if (cnt == 3'd0) begin
            r = 3'd1;
        end else if (cnt > STUFF_LIMIT) begin
            r = STUFF_LIMIT;
        end else begin
            r = cnt;
        end
        return r;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small byte FIFO with valid/ready read side.
// A write while full is dropped (reported on 'dropped') unless a pop happens
// in the same cycle. No write-to-read bypass: a byte written into an empty
// FIFO becomes visible the following cycle.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_ready,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       dropped
);
    localparam int              AW         = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0]   PTR_ONE    = AW'(1);
    localparam logic [AW:0]     CNT_ONE    = (AW + 1)'(1);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          full_s;
    logic          pop_s;
    logic          push_s;

    assign full_s   = (count_r == FULL_COUNT);
    assign rd_valid = (count_r != '0);
    assign pop_s    = rd_valid && rd_ready;
    assign push_s   = wr_en && (!full_s || pop_s);
    assign dropped  = wr_en && full_s && !pop_s;
    assign rd_data  = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/data_field_capture.sv
// CAN data-field capture: majority-vote bit decision, destuffing with stuff
// error detection, MSB-first byte assembly and delivery through byte_fifo.
// Optional running CRC-15 over data bits when DATA_CRC_EN is defined
// (adds crcSeed / crcOut ports).
module data_field_capture
    import can_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_BYTES  = 8
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        enable,
    input  logic        completeConfig,
    input  logic [3:0]  msgSize,
    input  logic        dIn,
    input  logic        samplePulse,
    input  logic        rateSelector,
    input  logic        stuffSeedBit,
    input  logic [2:0]  stuffSeedCount,
    output logic [7:0]  dataByte,
    output logic        dataValid,
    input  logic        dataReady,
    output logic        dataDone,
    output logic        stuffError,
    output logic        overflow
`ifdef DATA_CRC_EN
    ,
    input  logic [14:0] crcSeed,
    output logic [14:0] crcOut
`endif
);
    localparam logic [3:0] BYTE_CLAMP =
        (MAX_BYTES > MAX_DLC_BYTES) ? 4'(MAX_DLC_BYTES) : 4'(MAX_BYTES);

    dfc_state_t state_r, next_state_s;

    logic [3:0] bytes_left_r;
    logic       prev_r;
    logic [2:0] run_r;
    logic [2:0] bit_cnt_r;
    logic [7:0] byte_r;
    logic [1:0] pcnt_r;
    logic [1:0] samp_r;
    logic       bit_valid_r;
    logic       bit_val_r;
    logic       done_r;
    logic       stuff_err_r;
    logic       ovf_r;

    logic       data_bit_s;
    logic       stuff_bit_s;
    logic       stuff_viol_s;
    logic       push_s;
    logic [7:0] push_data_s;
    logic       fifo_drop_s;

    assign dataDone   = done_r;
    assign stuffError = stuff_err_r;
    assign overflow   = ovf_r;

    // FSM state register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode and per-bit classification (stuff / data / violation).
    always_comb begin
        next_state_s = state_r;
        data_bit_s   = 1'b0;
        stuff_bit_s  = 1'b0;
        stuff_viol_s = 1'b0;
        push_s       = 1'b0;
        push_data_s  = {byte_r[6:0], bit_val_r};
        if (!enable) begin
            next_state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (completeConfig) begin
                        next_state_s = ST_LOAD;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (bytes_left_r == 4'd0) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (bit_valid_r) begin
                        if (run_r == STUFF_LIMIT) begin
                            if (bit_val_r == prev_r) begin
                                stuff_viol_s = 1'b1;
                                next_state_s = ST_ERROR;
                            end else begin
                                stuff_bit_s = 1'b1;
                            end
                        end else begin
                            data_bit_s = 1'b1;
                            if (bit_cnt_r == 3'd7) begin
                                push_s = 1'b1;
                                if (bytes_left_r == 4'd1) begin
                                    next_state_s = ST_DONE;
                                end else begin
                                    next_state_s = ST_RECV;
                                end
                            end else begin
                                next_state_s = ST_RECV;
                            end
                        end
                    end else begin
                        next_state_s = ST_RECV;
                    end
                end
                ST_DONE:  next_state_s = ST_DONE;
                ST_ERROR: next_state_s = ST_ERROR;
                default:  next_state_s = ST_IDLE;
            endcase
        end
    end

    // Byte count, stuffing run tracker and byte shift register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            bytes_left_r <= 4'd0;
            prev_r       <= 1'b0;
            run_r        <= 3'd0;
            bit_cnt_r    <= 3'd0;
            byte_r       <= 8'h00;
        end else begin
            // msgSize is only valid alongside completeConfig, so capture it there.
            if ((state_r == ST_IDLE) && enable && completeConfig) begin
                bytes_left_r <= (msgSize > BYTE_CLAMP) ? BYTE_CLAMP : msgSize;
            end else if (push_s) begin
                bytes_left_r <= bytes_left_r - 4'd1;
            end
            if (state_r == ST_LOAD) begin
                prev_r    <= stuffSeedBit;
                run_r     <= seed_run(stuffSeedCount);
                bit_cnt_r <= 3'd0;
                byte_r    <= 8'h00;
            end else if (stuff_bit_s) begin
                prev_r <= bit_val_r;
                run_r  <= 3'd1;
            end else if (data_bit_s) begin
                byte_r    <= {byte_r[6:0], bit_val_r};
                bit_cnt_r <= bit_cnt_r + 3'd1;
                prev_r    <= bit_val_r;
                run_r     <= (bit_val_r == prev_r) ? (run_r + 3'd1) : 3'd1;
            end
        end
    end

    // Sample collection and registered bit decision (majority of three or single).
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pcnt_r      <= 2'd0;
            samp_r      <= 2'b00;
            bit_valid_r <= 1'b0;
            bit_val_r   <= 1'b0;
        end else begin
            bit_valid_r <= 1'b0;
            if ((state_r == ST_LOAD) || !enable) begin
                pcnt_r <= 2'd0;
            end else if ((state_r == ST_RECV) && samplePulse) begin
                if (!rateSelector) begin
                    bit_valid_r <= 1'b1;
                    bit_val_r   <= dIn;
                    pcnt_r      <= 2'd0;
                end else begin
                    case (pcnt_r)
                        2'd0: begin
                            samp_r[0] <= dIn;
                            pcnt_r    <= 2'd1;
                        end
                        2'd1: begin
                            samp_r[1] <= dIn;
                            pcnt_r    <= 2'd2;
                        end
                        2'd2: begin
                            bit_val_r   <= majority3(samp_r[0], samp_r[1], dIn);
                            bit_valid_r <= 1'b1;
                            pcnt_r      <= 2'd0;
                        end
                        default: pcnt_r <= 2'd0;
                    endcase
                end
            end
        end
    end

    // Status flags: done level follows DONE state; error and overflow are sticky.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            done_r      <= 1'b0;
            stuff_err_r <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            done_r <= (next_state_s == ST_DONE);
            if (stuff_viol_s) begin
                stuff_err_r <= 1'b1;
            end
            if (fifo_drop_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .resetN   (resetN),
        .wr_en    (push_s),
        .wr_data  (push_data_s),
        .rd_ready (dataReady),
        .rd_data  (dataByte),
        .rd_valid (dataValid),
        .dropped  (fifo_drop_s)
    );

`ifdef DATA_CRC_EN
    logic [14:0] crc_r;

    // Running CRC-15 over data bits only; held in every other cycle.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            crc_r <= 15'h0000;
        end else if (state_r == ST_LOAD) begin
            crc_r <= crcSeed;
        end else if (data_bit_s) begin
            crc_r <= crc15_step(crc_r, bit_val_r);
        end
    end

    assign crcOut = crc_r;
`endif

endmodule

// File: tb/tb_data_field_capture.sv
// Scoreboard bench for data_field_capture: stimulus tasks queue expected bytes,
// an independent monitor compares every FIFO handshake against the queue.
module tb_data_field_capture;

    logic        clk = 1'b0;
    logic        resetN;
    logic        enable;
    logic        completeConfig;
    logic [3:0]  msgSize;
    logic        dIn;
    logic        samplePulse;
    logic        rateSelector;
    logic        stuffSeedBit;
    logic [2:0]  stuffSeedCount;
    logic [7:0]  dataByte;
    logic        dataValid;
    logic        dataReady;
    logic        dataDone;
    logic        stuffError;
    logic        overflow;
`ifdef DATA_CRC_EN
    logic [14:0] crcSeed;
    logic [14:0] crcOut;
`endif

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    logic       noisy;
    logic       tx_prev;
    int         tx_run;

    always #5 clk = ~clk;

    data_field_capture #(.FIFO_DEPTH(4), .MAX_BYTES(8)) dut (
        .clk            (clk),
        .resetN         (resetN),
        .enable         (enable),
        .completeConfig (completeConfig),
        .msgSize        (msgSize),
        .dIn            (dIn),
        .samplePulse    (samplePulse),
        .rateSelector   (rateSelector),
        .stuffSeedBit   (stuffSeedBit),
        .stuffSeedCount (stuffSeedCount),
        .dataByte       (dataByte),
        .dataValid      (dataValid),
        .dataReady      (dataReady),
        .dataDone       (dataDone),
        .stuffError     (stuffError),
        .overflow       (overflow)
`ifdef DATA_CRC_EN
        ,
        .crcSeed        (crcSeed),
        .crcOut         (crcOut)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Monitor: every accepted FIFO byte must match the head of the scoreboard.
    always @(negedge clk) begin
        if (resetN === 1'b1 && dataValid === 1'b1 && dataReady === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_byte: got %0h expected none", dataByte);
            end else begin
                check("fifo_byte", {24'h0, dataByte}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic s);
        dIn = s;
        samplePulse = 1'b1;
        tick();
        samplePulse = 1'b0;
        tick();
    endtask

    // One bus bit; in three-sample mode the first sample is inverted when noisy.
    task automatic send_bit(input logic b);
        if (rateSelector) begin
            for (int k = 0; k < 3; k++) begin
                pulse((noisy && k == 0) ? ~b : b);
            end
        end else begin
            pulse(b);
        end
    endtask

    // Transmitter-side stuffer: inserts a complement bit after five equal bits.
    task automatic send_data_bit(input logic b);
        if (tx_run == 5) begin
            send_bit(~tx_prev);
            tx_prev = ~tx_prev;
            tx_run  = 1;
        end
        send_bit(b);
        if (b == tx_prev) tx_run++;
        else              tx_run = 1;
        tx_prev = b;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            send_data_bit(v[i]);
        end
    endtask

    task automatic start_frame(input logic [3:0] size, input logic sb, input logic [2:0] sc,
                               input logic rate);
        rateSelector   = rate;
        stuffSeedBit   = sb;
        stuffSeedCount = sc;
        msgSize        = size;
        enable         = 1'b1;
        completeConfig = 1'b1;
        tick();
        completeConfig = 1'b0;
        msgSize        = 4'hF;
        tick();
        tx_prev = sb;
        tx_run  = (sc == 3'd0) ? 1 : int'(sc);
    endtask

    task automatic end_frame();
        enable = 1'b0;
        tick();
        tick();
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        enable = 1'b0; completeConfig = 1'b0; samplePulse = 1'b0; dIn = 1'b0;
        tick();
        exp_q.delete();
        check("rst_valid",  {31'h0, dataValid},  32'h0);
        check("rst_done",   {31'h0, dataDone},   32'h0);
        check("rst_stuff",  {31'h0, stuffError}, 32'h0);
        check("rst_ovf",    {31'h0, overflow},   32'h0);
        resetN = 1'b1;
        tick();
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        dataReady = 1'b1;
        while (dataValid && n < 40) begin
            tick();
            n++;
        end
        tick();
        check({name, "_drained"}, {31'h0, dataValid}, 32'h0);
        check({name, "_queue"}, exp_q.size(), 32'h0);
    endtask

    function automatic logic [14:0] crc_model(input logic [14:0] c, input logic b);
        logic fb;
        fb = b ^ c[14];
        return {c[13:0], 1'b0} ^ (fb ? 15'h4599 : 15'h0000);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        resetN = 1'b0; enable = 1'b0; completeConfig = 1'b0; msgSize = 4'h0;
        dIn = 1'b0; samplePulse = 1'b0; rateSelector = 1'b0; stuffSeedBit = 1'b0;
        stuffSeedCount = 3'd1; dataReady = 1'b1; noisy = 1'b0;
`ifdef DATA_CRC_EN
        crcSeed = 15'h0000;
`endif
        tick();
        do_reset();

        // Majority mode, one byte 0xA5, seed (1,1).
        start_frame(4'd1, 1'b1, 3'd1, 1'b1);
        exp_q.push_back(8'hA5);
        send_byte(8'hA5);
        tick();
        check("a5_done",  {31'h0, dataDone},   32'h1);
        check("a5_stuff", {31'h0, stuffError}, 32'h0);
        drain("a5");
        end_frame();
        check("a5_done_clear", {31'h0, dataDone}, 32'h0);

        // Zero-length data field: done two clocks after completeConfig.
        start_frame(4'd0, 1'b1, 3'd1, 1'b0);
        check("dlc0_done",  {31'h0, dataDone},  32'h1);
        check("dlc0_valid", {31'h0, dataValid}, 32'h0);
        end_frame();

        // Eight zeros with one stuff bit after the fifth zero.
        start_frame(4'd1, 1'b1, 3'd1, 1'b0);
        exp_q.push_back(8'h00);
        send_byte(8'h00);
        tick();
        check("zero_done",  {31'h0, dataDone},   32'h1);
        check("zero_stuff", {31'h0, stuffError}, 32'h0);
        drain("zero");
        end_frame();

        // Seed (0,4) then bus 0,0: second zero sits in a stuff position.
        start_frame(4'd1, 1'b0, 3'd4, 1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        tick();
        check("err_flag",  {31'h0, stuffError}, 32'h1);
        check("err_done",  {31'h0, dataDone},   32'h0);
        check("err_valid", {31'h0, dataValid},  32'h0);
        send_bit(1'b1);
        send_bit(1'b0);
        check("err_nopush", {31'h0, dataValid}, 32'h0);
        end_frame();
        check("err_sticky", {31'h0, stuffError}, 32'h1);
        do_reset();

        // DLC 12 clamps to 8 bytes; consumer always ready.
        start_frame(4'hC, 1'b0, 3'd1, 1'b0);
        for (int b = 1; b <= 8; b++) begin
            exp_q.push_back(8'(b));
            send_byte(8'(b));
        end
        tick();
        check("dlc12_done", {31'h0, dataDone}, 32'h1);
        drain("dlc12");
        check("dlc12_ovf", {31'h0, overflow}, 32'h0);
        end_frame();

        // Overflow: consumer stalled, six bytes into a four-entry FIFO.
        dataReady = 1'b0;
        start_frame(4'd6, 1'b1, 3'd2, 1'b0);
        for (int b = 1; b <= 6; b++) begin
            if (b <= 4) exp_q.push_back(8'(b * 17));
            send_byte(8'(b * 17));
        end
        tick();
        check("ovf_flag",  {31'h0, overflow},  32'h1);
        check("ovf_done",  {31'h0, dataDone},  32'h1);
        check("ovf_valid", {31'h0, dataValid}, 32'h1);
        check("ovf_head",  {24'h0, dataByte},  32'h11);
        drain("ovf");
        end_frame();
        check("ovf_sticky", {31'h0, overflow}, 32'h1);
        do_reset();

        // Majority vote with one dissenting sample per bit: 0xFF.
        noisy = 1'b1;
        start_frame(4'd1, 1'b1, 3'd1, 1'b1);
        exp_q.push_back(8'hFF);
        send_byte(8'hFF);
        tick();
        check("maj_done",  {31'h0, dataDone},   32'h1);
        check("maj_stuff", {31'h0, stuffError}, 32'h0);
        drain("maj");
        end_frame();
        noisy = 1'b0;

        // Reset mid-frame discards FIFO content and state.
        dataReady = 1'b0;
        start_frame(4'd2, 1'b0, 3'd1, 1'b0);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C);
        send_data_bit(1'b1);
        tick();
        check("mid_valid", {31'h0, dataValid}, 32'h1);
        do_reset();
        tick();
        check("mid_after_valid", {31'h0, dataValid}, 32'h0);
        dataReady = 1'b1;

`ifdef DATA_CRC_EN
        begin
            logic [14:0] c;
            logic [7:0]  v;
            crcSeed = 15'h0000;
            start_frame(4'd1, 1'b0, 3'd1, 1'b0);
            exp_q.push_back(8'h80);
            send_data_bit(1'b1);
            check("crc_first", {17'h0, crcOut}, {17'h0, 15'h4599});
            c = 15'h4599;
            v = 8'h80;
            for (int i = 6; i >= 0; i--) begin
                send_data_bit(v[i]);
                c = crc_model(c, v[i]);
            end
            tick();
            check("crc_final", {17'h0, crcOut}, {17'h0, c});
            tick();
            check("crc_held", {17'h0, crcOut}, {17'h0, c});
            drain("crc");
            end_frame();
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_field_capture.md
Name: data_field_capture

Overview:
- Downstream neighbour of sizeDetect and idComparator in the CAN ch_unit receive path.
- After sizeDetect asserts completeConfig, it receives the data field from the sampled bus.
- Per bit: majority-votes the samples, removes stuff bits and flags stuff errors, then assembles MSB-first bytes.
- Delivers bytes through a small valid/ready FIFO and flags completion after msgSize bytes.

Parameters:
- FIFO_DEPTH, 4, byte entries in output FIFO (power of two, >=2).
- MAX_BYTES, 8, clamp for the data length code (classic CAN).

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous active-low reset.
- enable  in  1  frame active; low aborts capture.
- completeConfig  in  1  pulse from sizeDetect; msgSize valid this cycle.
- msgSize  in  4  data length code.
- dIn  in  1  bus bit level.
- samplePulse  in  1  one-cycle sample strobe (from oneshot).
- rateSelector  in  1  1 = three samples per bit, majority vote; 0 = one sample per bit.
- stuffSeedBit  in  1  last destuffed-stream bit before the data field.
- stuffSeedCount  in  3  run length of stuffSeedBit (1..5) before the data field.
- dataByte  out  8  FIFO head byte.
- dataValid  out  1  FIFO non-empty.
- dataReady  in  1  consumer pop; a pop occurs when dataValid && dataReady.
- dataDone  out  1  all bytes received (level, held until exit from DONE).
- stuffError  out  1  sticky: six equal consecutive bits seen.
- overflow  out  1  sticky: byte dropped because FIFO full.

Behaviour:
- Reset values:
  - all outputs 0, FIFO empty, FSM IDLE.
  - Reset mid-frame discards everything immediately.
- Bit decision:
  - rateSelector=1: a mod-3 pulse counter captures dIn on each samplePulse; the bit equals the majority of three, decided on the third pulse.
  - rateSelector=0: every pulse is a bit.
  - Decision is registered one clk after the deciding pulse.
  - Pulse counter clears on entry to RECV.
- FSM states: IDLE, LOAD, RECV, DONE, ERROR.
- IDLE -> LOAD when enable && completeConfig.
- LOAD (one cycle):
  - latches bytesLeft = min(msgSize, MAX_BYTES); codes 9..15 become 8.
  - latches prevBit/runCount from the seeds; seed count 0 is treated as 1.
  - goes to DONE if bytesLeft==0, else to RECV.
- RECV, per decided bit:
  - If runCount==5, the bit is a stuff bit. If it equals prevBit -> ERROR. Otherwise discard it, set prevBit=bit, runCount=1.
  - Otherwise the bit is data: shift it into byteReg MSB-first and increment bitCnt. runCount increments if bit==prevBit, else resets to 1; prevBit=bit.
  - On the 8th data bit: push byteReg into the FIFO in the same cycle as the decision, decrement bytesLeft, clear bitCnt. If bytesLeft reaches 0 -> DONE.
- DONE: dataDone=1; returns to IDLE when enable falls.
- ERROR: stuffError=1 (sticky until reset); no further pushes; returns to IDLE when enable falls.
- enable low in any state -> IDLE next cycle:
  - partial byte discarded.
  - FIFO contents retained; popping continues.
  - dataDone clears.
- FIFO:
  - Push when full: byte dropped, overflow=1 (sticky until reset).
  - Simultaneous push and pop when full: both succeed.
  - Simultaneous push and pop when empty: byte is written and dataValid rises next cycle (no bypass).
  - dataByte is stable while dataValid && !dataReady.
- Stuff bits never reach the FIFO and never count toward bytes. A stuff bit pending after the final data bit is not consumed; the CRC stage owns it.

Optional Feature:
- Macro DATA_CRC_EN.
- When defined, adds ports:
  - crcSeed in 15: CRC-15 state after the control field, loaded in LOAD.
  - crcOut out 15: running CRC.
- Each data bit updates CAN CRC-15 (polynomial 0x4599): fb = bit ^ crc[14]; crc = {crc[13:0],1'b0} ^ (fb ? 15'h4599 : 0).
- Stuff bits are excluded from the CRC; crcOut is held in DONE.
- Without the macro: no CRC logic and no crc ports.

Decomposition:
- Shared package can_rx_pkg:
  - FSM state enum dfc_state_t.
  - constants CAN_CRC15_POLY=15'h4599, STUFF_LIMIT=3'd5, MAX_DLC_BYTES=8.
- One natural sub-module: byte_fifo (parameterised depth, valid/ready, full/empty), instantiated once.

Test Plan:
- rateSelector=1, msgSize=1, byte 0xA5 with seed (1,1) -> dataByte 0xA5, dataValid, then dataDone=1; stuffError=0.
- msgSize=0 with completeConfig -> dataDone=1 two clks later; no FIFO pushes.
- msgSize=1, seed (1,1), eight zeros with a 1 stuff bit after the 5th zero (9 bit times) -> 0x00 captured, no error.
- Seed (0,4), bus 0,0 -> second 0 is a stuff-position violation -> ERROR, stuffError=1, no byte pushed.
- msgSize=4'hC, dataReady=1, bytes 0x01..0x08 -> exactly 8 bytes in order, then dataDone.
- FIFO_DEPTH=4, dataReady=0, msgSize=6 -> 4 bytes held, overflow=1. Popping then yields the first 4 bytes in order.
- rateSelector=1, samples 0,1,1 for each bit of 0xFF... -> each bit decides 1 (majority).
- With DATA_CRC_EN, seed 0, byte 0x80 -> crcOut = 15'h4599 after the first bit, then shifted per the update rule.
